// File: rtl/cnn_pkg.sv
// Shared types and the int8 requantisation clamp for the CNN stream engines.
// CONV_RELU_EN selects a ReLU clamp (0..127) instead of signed int8 saturation.
package cnn_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned PROD_W = 2 * PIX_W;

    typedef logic signed [PIX_W-1:0]  pixel_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    // Per-stage qualifier carried alongside the datapath.
    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    function automatic pixel_t sat_int8(input acc_t v);
`ifdef CONV_RELU_EN
        if (v < acc_t'(0)) begin
            return pixel_t'(8'h00);
        end else if (v > acc_t'(127)) begin
            return pixel_t'(8'h7F);
        end
        return pixel_t'(v);
`else
        if (v < acc_t'(-128)) begin
            return pixel_t'(8'h80);
        end else if (v > acc_t'(127)) begin
            return pixel_t'(8'h7F);
        end
        return pixel_t'(v);
`endif
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row delay lines of IN_DIM pixels; presents the K-pixel vertical column ending at
// the incoming pixel (slot 0 = incoming row, slot K-1 = oldest row).
module conv_line_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned IN_DIM = 32,
    parameter int unsigned K      = 5
) (
    input  logic                   clk,
    input  logic                   valid_i,
    input  logic [PIX_W-1:0]       pixel_i,
    output logic [K*PIX_W-1:0]     col_o
);

    logic [PIX_W-1:0] line_q [K-1][IN_DIM];

    // Contents are deliberately not reset; the engine's counters gate their use.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            line_q[0][0] <= pixel_i;
            for (int r = 1; r < K - 1; r++) begin
                line_q[r][0] <= line_q[r-1][IN_DIM-1];
            end
            for (int r = 0; r < K - 1; r++) begin
                for (int c = 1; c < IN_DIM; c++) begin
                    line_q[r][c] <= line_q[r][c-1];
                end
            end
        end
    end

    always_comb begin
        col_o[PIX_W-1:0] = pixel_i;
        for (int r = 1; r < K; r++) begin
            col_o[r*PIX_W +: PIX_W] = line_q[r-1][IN_DIM-1];
        end
    end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK valid-mode convolution with runtime weights/bias and int8 requantisation.
// Output clamp is ReLU when CONV_RELU_EN is defined, signed saturation otherwise.
module conv2d_stream_engine
    import cnn_pkg::*;
#(
    parameter int unsigned IN_DIM = 32,
    parameter int unsigned K      = 5,
    parameter int unsigned SHIFT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_wr_en,
    input  logic [4:0]  w_addr,
    input  logic [15:0] w_data,
    input  logic        valid_in,
    input  logic [7:0]  pixel_in,
    output logic        valid_out,
    output logic [7:0]  pixel_out,
    output logic        all_done
);

    localparam int unsigned OUT_DIM = IN_DIM - K + 1;
    localparam int unsigned NTAP    = K * K;
    localparam int unsigned CNT_W   = $clog2(IN_DIM);
    localparam acc_t        RND     = acc_t'((1 << SHIFT) >> 1);

    logic [CNT_W-1:0]   in_row_q, in_row_d;
    logic [CNT_W-1:0]   in_col_q, in_col_d;
    pixel_t             w_q [NTAP];
    logic signed [15:0] bias_q;
    logic [K*PIX_W-1:0] col_c;
    pixel_t             win_q [K][K];
    prod_t              prod_q [NTAP];
    acc_t               acc_q;
    acc_t               sum_c;
    acc_t               rq_c;
    tag_t               t0_q, t1_q, t2_q;
    logic               idle_c;
    logic               win_vld_c;
    logic               win_last_c;

    conv_line_buffer #(
        .IN_DIM (IN_DIM),
        .K      (K)
    ) u_line_buffer (
        .clk     (clk),
        .valid_i (valid_in),
        .pixel_i (pixel_in),
        .col_o   (col_c)
    );

    always_comb begin
        in_row_d = in_row_q;
        in_col_d = in_col_q;
        if (valid_in) begin
            if (in_col_q == CNT_W'(IN_DIM - 1)) begin
                in_col_d = '0;
                in_row_d = (in_row_q == CNT_W'(IN_DIM - 1)) ? '0 : in_row_q + CNT_W'(1);
            end else begin
                in_col_d = in_col_q + CNT_W'(1);
            end
        end
    end

    assign win_vld_c  = valid_in && (in_row_q >= CNT_W'(K - 1)) && (in_col_q >= CNT_W'(K - 1));
    assign win_last_c = (in_row_q == CNT_W'(IN_DIM - 1)) && (in_col_q == CNT_W'(IN_DIM - 1));
    assign idle_c     = (in_row_q == '0) && (in_col_q == '0) &&
                        !t0_q.vld && !t1_q.vld && !t2_q.vld && !valid_out;

    // Control: position counters and pipeline qualifiers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_row_q <= '0;
            in_col_q <= '0;
            t0_q     <= '0;
            t1_q     <= '0;
            t2_q     <= '0;
        end else begin
            in_row_q <= in_row_d;
            in_col_q <= in_col_d;
            t0_q     <= '{vld: win_vld_c, last: win_last_c};
            t1_q     <= t0_q;
            t2_q     <= t1_q;
        end
    end

    // Coefficients only change while no frame or result is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) begin
                w_q[i] <= '0;
            end
            bias_q <= '0;
        end else if (w_wr_en && idle_c) begin
            for (int i = 0; i < NTAP; i++) begin
                if (w_addr == 5'(i)) begin
                    w_q[i] <= pixel_t'(w_data[7:0]);
                end
            end
            if (w_addr == 5'(NTAP)) begin
                bias_q <= w_data;
            end
        end
    end

    // Datapath: window shift on accept, then multiply and accumulate stages.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K-1] <= pixel_t'(col_c[(K-1-r)*PIX_W +: PIX_W]);
            end
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                prod_q[r*K+c] <= prod_t'(win_q[r][c]) * prod_t'(w_q[r*K+c]);
            end
        end
        acc_q <= sum_c;
    end

    always_comb begin
        sum_c = acc_t'(bias_q);
        for (int i = 0; i < NTAP; i++) begin
            sum_c = sum_c + acc_t'(prod_q[i]);
        end
        rq_c = (acc_q + RND) >>> SHIFT;
    end

    // Requantise and flag end of frame; the end-of-frame set wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            pixel_out <= '0;
            all_done  <= 1'b0;
        end else begin
            valid_out <= t2_q.vld;
            if (t2_q.vld) begin
                pixel_out <= sat_int8(rq_c);
            end
            if (t2_q.vld && t2_q.last) begin
                all_done <= 1'b1;
            end else if (valid_in) begin
                all_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench for conv2d_stream_engine: a frame-level reference model pushes expected
// pixels with their due cycle; a negedge monitor pops and compares.
module tb_conv2d_stream_engine;

    localparam int IN_DIM  = 32;
    localparam int K       = 5;
    localparam int SHIFT   = 2;
    localparam int NTAP    = K * K;
    localparam int LAT     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_wr_en;
    logic [4:0]  w_addr;
    logic [15:0] w_data;
    logic        valid_in;
    logic [7:0]  pixel_in;
    logic        valid_out;
    logic [7:0]  pixel_out;
    logic        all_done;

    conv2d_stream_engine #(
        .IN_DIM (IN_DIM),
        .K      (K),
        .SHIFT  (SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_wr_en   (w_wr_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .valid_in  (valid_in),
        .pixel_in  (pixel_in),
        .valid_out (valid_out),
        .pixel_out (pixel_out),
        .all_done  (all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     val;
        longint due;
        bit     last;
    } exp_t;

    exp_t   q[$];
    int     img [IN_DIM][IN_DIM];
    int     mw [NTAP];
    int     mbias;
    int     tw [NTAP];
    int     m_row, m_col;
    longint cyc = 0;
    bit     acc_edge = 1'b0;
    bit     exp_done = 1'b0;
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clip(input longint v);
`ifdef CONV_RELU_EN
        if (v < 0) return 0;
`else
        if (v < -128) return -128;
`endif
        if (v > 127) return 127;
        return int'(v);
    endfunction

    // Convolution of the window whose bottom-right corner is (r, c), requantised.
    function automatic int ref_pixel(input int r, input int c);
        longint acc = longint'(mbias);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                acc += longint'(mw[i*K+j]) * longint'(img[r-K+1+i][c-K+1+j]);
        acc = (acc + ((longint'(1) << SHIFT) >> 1)) >>> SHIFT;
        return clip(acc);
    endfunction

    function automatic void model_write(input int addr, input int data);
        logic [15:0]        d;
        logic signed [7:0]  lo;
        logic signed [15:0] sd;
        d  = 16'(data);
        lo = d[7:0];
        sd = d;
        if (addr < NTAP) mw[addr] = int'(lo);
        else if (addr == NTAP) mbias = int'(sd);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NTAP; i++) mw[i] = 0;
        mbias = 0;
        m_row = 0;
        m_col = 0;
        q.delete();
    endfunction

    // Called at the negedge where the pixel is driven; it is accepted on the next posedge.
    function automatic void model_accept(input int p);
        img[m_row][m_col] = p;
        if (m_row >= K - 1 && m_col >= K - 1)
            q.push_back('{val: ref_pixel(m_row, m_col), due: cyc + LAT,
                          last: (m_row == IN_DIM - 1 && m_col == IN_DIM - 1)});
        if (m_col == IN_DIM - 1) begin
            m_col = 0;
            m_row = (m_row == IN_DIM - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        acc_edge <= valid_in && !rst;
    end

    always @(negedge clk) begin
        bit exp_last;
        exp_last = 1'b0;
        if (rst) begin
            exp_done = 1'b0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_last = q[0].last;
                check("valid_out_due", valid_out, 1);
                if (valid_out) check("pixel_out", int'($signed(pixel_out)), q[0].val);
                void'(q.pop_front());
            end else begin
                check("valid_out_quiet", valid_out, 0);
            end
            if (exp_last) exp_done = 1'b1;
            else if (acc_edge) exp_done = 1'b0;
            check("all_done", all_done, exp_done);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            w_wr_en  = 1'b0;
        end
    endtask

    task automatic write_w(input int addr, input int data, input bit lands);
        @(negedge clk);
        valid_in = 1'b0;
        w_wr_en  = 1'b1;
        w_addr   = 5'(addr);
        w_data   = 16'(data);
        if (lands) model_write(addr, data);
    endtask

    task automatic load_weights(input int b);
        for (int i = 0; i < NTAP; i++) write_w(i, tw[i], 1'b1);
        write_w(NTAP, b, 1'b1);
        idle(1);
    endtask

    // mode 0: constant cval, mode 1: random int8. Optional write strobe alongside pixel wr_idx.
    task automatic run_frame(input int mode, input int cval, input int bubble_pct, input int n_pix,
                             input int wr_idx, input int wr_addr, input int wr_data, input bit wr_lands);
        int p;
        for (int i = 0; i < n_pix; i++) begin
            while (bubble_pct > 0 && $urandom_range(99) < bubble_pct) idle(1);
            @(negedge clk);
            p        = (mode == 0) ? cval : int'($urandom_range(255)) - 128;
            valid_in = 1'b1;
            pixel_in = 8'(p);
            w_wr_en  = (i == wr_idx);
            w_addr   = 5'(wr_addr);
            w_data   = 16'(wr_data);
            if (i == wr_idx && wr_lands) model_write(wr_addr, wr_data);
            model_accept(p);
        end
    endtask

    task automatic drain();
        idle(1);
        for (int t = 0; t < 40 && q.size() > 0; t++) idle(1);
        check("drain_outstanding", q.size(), 0);
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; pixel_in = '0; w_wr_en = 1'b0; w_addr = '0; w_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid_out", valid_out, 0);
        check("rst_pixel_out", pixel_out, 0);
        check("rst_all_done", all_done, 0);
        #1 rst = 1'b0;

        // 1: box filter of ones
        for (int i = 0; i < NTAP; i++) tw[i] = 1;
        load_weights(0);
        run_frame(0, 1, 0, IN_DIM * IN_DIM, -1, 0, 0, 1'b0);
        drain();
        check("all_done_frame1", all_done, 1);

        // 2: centre tap only, random pixels; out-of-range address is ignored
        write_w(NTAP + 1, 16'h1234, 1'b0);
        for (int i = 0; i < NTAP; i++) tw[i] = (i == NTAP / 2) ? 1 : 0;
        load_weights(0);
        run_frame(1, 0, 0, IN_DIM * IN_DIM, -1, 0, 0, 1'b0);
        drain();

        // 3: saturation both ways
        for (int i = 0; i < NTAP; i++) tw[i] = 127;
        load_weights(0);
        run_frame(0, 127, 0, IN_DIM * IN_DIM, -1, 0, 0, 1'b0);
        drain();
        for (int i = 0; i < NTAP; i++) tw[i] = 16'hFF80;
        load_weights(0);
        run_frame(0, 127, 0, IN_DIM * IN_DIM, -1, 0, 0, 1'b0);
        drain();

        // 4: rounding of bias-only results; bias 5 written in the same cycle as pixel (0,0)
        for (int i = 0; i < NTAP; i++) tw[i] = 0;
        load_weights(6);
        run_frame(0, 55, 0, IN_DIM * IN_DIM, -1, 0, 0, 1'b0);
        drain();
        run_frame(0, 55, 0, IN_DIM * IN_DIM, 0, NTAP, 5, 1'b1);
        drain();
        load_weights(16'hFFFA);
        run_frame(0, 55, 0, IN_DIM * IN_DIM, -1, 0, 0, 1'b0);
        drain();

        // 5: random coefficients with ~50% input bubbles
        for (int i = 0; i < NTAP; i++) tw[i] = int'($urandom_range(4)) - 2;
        load_weights(int'($urandom_range(400)) - 200);
        run_frame(1, 0, 50, IN_DIM * IN_DIM, -1, 0, 0, 1'b0);
        drain();

        // 6: reset mid-frame, then back-to-back frames with ignored in-flight writes
        run_frame(1, 0, 0, 400, -1, 0, 0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1; valid_in = 1'b0; w_wr_en = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_valid_out", valid_out, 0);
        check("midrst_all_done", all_done, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        load_weights(int'($urandom_range(400)) - 200);
        run_frame(1, 0, 10, IN_DIM * IN_DIM, 300, NTAP / 2, 100, 1'b0);
        run_frame(1, 0, 0, IN_DIM * IN_DIM, 0, NTAP, 16'h4000, 1'b0);
        drain();
        check("all_done_frame_b2b", all_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
